// File: rtl/level_to_pulse_gen_pkg.sv
// Shared constants for the level-to-pulse converter: edge selection codes
// and the width helper for the pulse counter.
package level_to_pulse_gen_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Counter must hold PULSE_CYCLES itself, so size for cycles+1 states.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/level_to_pulse_gen_if.sv
// Level input / pulse output pair of the level-to-pulse converter.
interface level_to_pulse_gen_if;
  logic i_data;
  logic o_pulse;

  modport master (output i_data, input o_pulse);
  modport slave  (input i_data, output o_pulse);
endinterface

// File: rtl/level_to_pulse_gen_sync_chain.sv
// N-stage flop synchronizer with async active-low reset; N=0 passes d through.
module level_to_pulse_gen_sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (N == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_sync
    logic [N-1:0] stg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg <= '0;
      end else begin
        stg[0] <= d;
        for (int i = 1; i < N; i++) stg[i] <= stg[i-1];
      end
    end

    assign q = stg[N-1];
  end

endmodule

// File: rtl/level_to_pulse_gen.sv
// Turns a (possibly asynchronous) level into a registered pulse of
// PULSE_CYCLES clocks on the selected edge; retriggers extend the pulse.
module level_to_pulse_gen
  import level_to_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int EDGE_MODE    = EDGE_RISE,
  parameter int PULSE_CYCLES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  level_to_pulse_gen_if.slave  bus
);

  localparam int CW = cnt_width(PULSE_CYCLES);

  logic          s, p;
  logic          rise, fall, hit;
  logic          pulse;
  logic [CW-1:0] cnt;

  level_to_pulse_gen_sync_chain #(.N(SYNC_STAGES)) u_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (bus.i_data),
    .q     (s)
  );

  assign rise = s & ~p;
  assign fall = ~s & p;

  always_comb begin
    hit = rise;
    case (EDGE_MODE)
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = rise;
    endcase
  end

  // p resets to 0, so a level already high at reset release counts as a rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p     <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      p <= s;
      if (hit) begin
        cnt   <= CW'(PULSE_CYCLES);
        pulse <= 1'b1;
      end else if (cnt != '0) begin
        cnt   <= cnt - CW'(1);
        pulse <= (cnt > CW'(1));
      end
    end
  end

  assign bus.o_pulse = pulse;

endmodule

// File: tb/tb_level_to_pulse_gen.sv
// Scoreboard bench: five parameter variants share one level input; a
// history-based model predicts every cycle's pulse vector.
module tb_level_to_pulse_gen;
  import level_to_pulse_gen_pkg::*;

  localparam int NC = 5;

  // Variants: 0 SS0/rise/1, 1 SS2/rise/1, 2 SS2/fall/1, 3 SS2/both/1, 4 SS1/rise/4
  function automatic int ss_of(input int g);
    case (g)
      0:       return 0;
      4:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int mode_of(input int g);
    case (g)
      2:       return EDGE_FALL;
      3:       return EDGE_BOTH;
      default: return EDGE_RISE;
    endcase
  endfunction

  function automatic int pw_of(input int g);
    return (g == 4) ? 4 : 1;
  endfunction

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          din   = 1'b0;
  logic [NC-1:0] pulse;

  always #10 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    level_to_pulse_gen_if u_if ();
    assign u_if.i_data = din;
    assign pulse[g]    = u_if.o_pulse;
    level_to_pulse_gen #(
      .SYNC_STAGES  (ss_of(g)),
      .EDGE_MODE    (mode_of(g)),
      .PULSE_CYCLES (pw_of(g))
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (u_if)
    );
  end

  // Reference model: dq[j-1] is the level sampled at the j-th edge since reset.
  bit            dq[$];
  logic [NC-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;

  function automatic bit d_at(input int j);
    if (j < 1 || j > dq.size()) return 1'b0;
    return dq[j-1];
  endfunction

  // An edge at clock j compares the levels seen SYNC_STAGES edges earlier.
  function automatic bit hit_at(input int g, input int j);
    bit a, b;
    if (j < 1) return 1'b0;
    a = d_at(j - ss_of(g));
    b = d_at(j - ss_of(g) - 1);
    case (mode_of(g))
      EDGE_FALL: return !a && b;
      EDGE_BOTH: return a != b;
      default:   return a && !b;
    endcase
  endfunction

  // Pulse is high after edge k iff any edge landed in the last PULSE_CYCLES clocks.
  function automatic logic [NC-1:0] expect_now();
    logic [NC-1:0] e;
    int k;
    e = '0;
    k = dq.size();
    for (int g = 0; g < NC; g++)
      for (int j = k - pw_of(g) + 1; j <= k; j++)
        if (hit_at(g, j)) e[g] = 1'b1;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      dq.delete();
      exp_q.push_back('0);
    end else begin
      dq.push_back(din);
      exp_q.push_back(expect_now());
    end
  end

  always @(negedge clk) begin
    logic [NC-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = '0;
      checks++;
      if (pulse !== e) begin
        errors++;
        $display("FAIL pulse t=%0t got=%b want=%b", $time, pulse, e);
      end
    end
  end

  bit   counting    = 1'b0;
  logic prev_p1     = 1'b0;
  int   pulse_rises = 0;

  always @(negedge clk) begin
    if (counting && pulse[1] && !prev_p1) pulse_rises++;
    prev_p1 = pulse[1];
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit d, prev;
    int nrise;

    rst_n = 1'b0; din = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(4);

    // single short high level, long held level, five-cycle level
    din = 1'b1; cyc(4);  din = 1'b0; cyc(8);
    din = 1'b1; cyc(10); din = 1'b0; cyc(8);
    din = 1'b1; cyc(5);  din = 1'b0; cyc(8);

    // second rise two cycles after the first: retrigger extends the pulse
    din = 1'b1; cyc(1); din = 1'b0; cyc(1); din = 1'b1; cyc(3);
    din = 1'b0; cyc(10);

    // toggle every cycle
    repeat (20) begin din = ~din; cyc(1); end
    din = 1'b0; cyc(8);

    // level already high when reset releases
    rst_n = 1'b0; din = 1'b1; cyc(2);
    rst_n = 1'b1; cyc(8);
    din = 1'b0; cyc(8);

    // reset asserted mid-pulse, between clock edges
    din = 1'b1;
    @(posedge clk); #3;
    checks++;
    if (pulse[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pulse got=%b want=1", pulse[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pulse !== '0) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b", pulse, {NC{1'b0}});
    end
    din = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(6);

    // random level: one pulse per synchronized rising transition
    counting = 1'b1; prev = 1'b0; nrise = 0;
    repeat (1000) begin
      d = 1'($urandom_range(0, 1));
      if (d && !prev) nrise++;
      prev = d;
      din  = d;
      cyc(1);
    end
    din = 1'b0;
    cyc(6);
    counting = 1'b0;
    checks++;
    if (pulse_rises != nrise) begin
      errors++;
      $display("FAIL random_pulse_count got=%0d want=%0d", pulse_rises, nrise);
    end

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
